// File: rtl/cpu_defs.sv
// Shared CPU definitions: instruction cache op encodings, geometry,
// memory read types and the cache controller state encoding.
package cpu_defs;

  localparam int ICACHE_SET_NUM    = 256;
  localparam int ICACHE_LINE_WORDS = 4;
  localparam int ICACHE_SET_W      = 8;
  localparam int ICACHE_TAG_W      = 20;

  localparam logic [2:0] ICACHE_OP_NOP     = 3'd0;
  localparam logic [2:0] ICACHE_OP_READ    = 3'd1;
  localparam logic [2:0] ICACHE_OP_IDX_INV = 3'd2;
  localparam logic [2:0] ICACHE_OP_HIT_INV = 3'd3;

  localparam logic MEM_RD_SINGLE = 1'b0;
  localparam logic MEM_RD_LINE   = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_MISS,
    ST_REFILL,
    ST_RESP
  } icache_state_t;

  // Encodings 4..7 are reserved and behave as NOP.
  function automatic logic icache_op_valid(input logic [2:0] op);
    return (op == ICACHE_OP_READ) || (op == ICACHE_OP_IDX_INV) ||
           (op == ICACHE_OP_HIT_INV);
  endfunction

endpackage

// File: rtl/icache_ram.sv
// Tag and data storage for the instruction cache: synchronous read,
// one write port shared by the tag and data arrays (same set).
module icache_ram
  import cpu_defs::*;
(
  input  logic                    clk,
  input  logic                    rd_en,
  input  logic [ICACHE_SET_W-1:0] rd_set,
  input  logic [1:0]              rd_word,
  output logic [ICACHE_TAG_W-1:0] rd_tag,
  output logic [31:0]             rd_data,
  input  logic                    wr_en,
  input  logic                    tag_wr_en,
  input  logic [ICACHE_SET_W-1:0] wr_set,
  input  logic [1:0]              wr_word,
  input  logic [ICACHE_TAG_W-1:0] wr_tag,
  input  logic [31:0]             wr_data
);

  logic [ICACHE_TAG_W-1:0] tag_mem  [ICACHE_SET_NUM];
  logic [31:0]             data_mem [ICACHE_SET_NUM*ICACHE_LINE_WORDS];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_mem[{wr_set, wr_word}] <= wr_data;
    end
    if (tag_wr_en) begin
      tag_mem[wr_set] <= wr_tag;
    end
    if (rd_en) begin
      rd_tag  <= tag_mem[rd_set];
      rd_data <= data_mem[{rd_set, rd_word}];
    end
  end

endmodule

// File: rtl/icache.sv
// Direct-mapped 4 KiB instruction cache: request latch, valid bits and
// the IDLE/LOOKUP/MISS/REFILL/RESP controller around icache_ram.
module icache
  import cpu_defs::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] icache_idx,
  input  logic [2:0]  icache_op,
  input  logic        icache_is_cached,
  input  logic [31:0] icache_pa,
  input  logic        is_icache_stall,
  output logic        icache_ready,
  output logic [31:0] icache_data,
  output logic        mem_rd_req,
  output logic        mem_rd_type,
  output logic [31:0] mem_rd_addr,
  input  logic        mem_rd_rdy,
  input  logic        mem_ret_valid,
  input  logic        mem_ret_last,
  input  logic [31:0] mem_ret_data
);

  icache_state_t state_reg, state_next;

  logic [11:2]               idx_reg;
  logic [2:0]                op_reg;
  logic [31:0]               pa_reg;
  logic                      cached_reg;
  logic [1:0]                beat_reg;
  logic [31:0]               resp_data_reg;
  logic [ICACHE_SET_NUM-1:0] valid_reg;

  logic [ICACHE_SET_W-1:0] req_set;
  logic [ICACHE_TAG_W-1:0] rd_tag;
  logic [31:0]             rd_data;
  logic                    tag_match, hit, lookup_done, accept;
  logic                    refill_beat, refill_last, fill_valid, inv_clr;
  logic [31:0]             lookup_data;
  logic                    unused_idx_bits;

  assign unused_idx_bits = ^icache_idx[1:0];
  assign req_set     = idx_reg[11:4];
  assign tag_match   = valid_reg[req_set] && (rd_tag == pa_reg[31:12]);
  assign hit         = (state_reg == ST_LOOKUP) && (op_reg == ICACHE_OP_READ) &&
                       cached_reg && tag_match;
  // Invalidates always complete in LOOKUP; only a READ can miss.
  assign lookup_done = (state_reg == ST_LOOKUP) && (hit || (op_reg != ICACHE_OP_READ));
  assign lookup_data = hit ? rd_data : 32'd0;
  assign accept      = icache_op_valid(icache_op) &&
                       ((state_reg == ST_IDLE) ||
                        (((state_reg == ST_RESP) || lookup_done) && !is_icache_stall));
  assign refill_beat = (state_reg == ST_REFILL) && mem_ret_valid;
  assign refill_last = refill_beat && mem_ret_last;
  assign fill_valid  = refill_last && cached_reg;
  assign inv_clr     = (state_reg == ST_LOOKUP) &&
                       ((op_reg == ICACHE_OP_IDX_INV) ||
                        ((op_reg == ICACHE_OP_HIT_INV) && tag_match));

  icache_ram u_ram (
    .clk       (clk),
    .rd_en     (accept),
    .rd_set    (icache_idx[11:4]),
    .rd_word   (icache_idx[3:2]),
    .rd_tag    (rd_tag),
    .rd_data   (rd_data),
    .wr_en     (refill_beat && cached_reg),
    .tag_wr_en (fill_valid),
    .wr_set    (req_set),
    .wr_word   (beat_reg),
    .wr_tag    (pa_reg[31:12]),
    .wr_data   (mem_ret_data)
  );

  always_comb begin
    state_next   = state_reg;
    icache_ready = lookup_done || (state_reg == ST_RESP);
    icache_data  = (state_reg == ST_RESP) ? resp_data_reg : lookup_data;
    mem_rd_req   = (state_reg == ST_MISS);
    mem_rd_type  = cached_reg ? MEM_RD_LINE : MEM_RD_SINGLE;
    mem_rd_addr  = cached_reg ? {pa_reg[31:4], 4'b0000} : pa_reg;
    case (state_reg)
      ST_IDLE:   if (accept) state_next = ST_LOOKUP;
      ST_LOOKUP: begin
        if (!lookup_done)        state_next = ST_MISS;
        else if (is_icache_stall) state_next = ST_RESP;
        else if (accept)          state_next = ST_LOOKUP;
        else                      state_next = ST_IDLE;
      end
      ST_MISS:   if (mem_rd_rdy) state_next = ST_REFILL;
      ST_REFILL: if (refill_last) state_next = ST_RESP;
      ST_RESP:   if (!is_icache_stall) state_next = accept ? ST_LOOKUP : ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      idx_reg       <= '0;
      op_reg        <= ICACHE_OP_NOP;
      pa_reg        <= '0;
      cached_reg    <= 1'b0;
      beat_reg      <= 2'd0;
      resp_data_reg <= 32'd0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        idx_reg    <= icache_idx[11:2];
        op_reg     <= icache_op;
        pa_reg     <= icache_pa;
        cached_reg <= icache_is_cached;
      end
      if (state_reg == ST_MISS) begin
        beat_reg <= 2'd0;
      end
      // An uncached return is a single beat, always the requested word.
      if (refill_beat) begin
        beat_reg <= beat_reg + 2'd1;
        if (!cached_reg || (beat_reg == idx_reg[3:2])) begin
          resp_data_reg <= mem_ret_data;
        end
      end
      if (lookup_done) begin
        resp_data_reg <= lookup_data;
      end
    end
  end

  for (genvar gi = 0; gi < ICACHE_SET_NUM; gi++) begin : g_valid
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_reg[gi] <= 1'b0;
      end else if (fill_valid && (req_set == ICACHE_SET_W'(gi))) begin
        valid_reg[gi] <= 1'b1;
      end else if (inv_clr && (req_set == ICACHE_SET_W'(gi))) begin
        valid_reg[gi] <= 1'b0;
      end
    end
  end

endmodule
